// File: rtl/ps2_rx_decoder.sv
// ps2_rx_decoder
//   PS/2 keyboard receiver and scancode decoder running entirely on reloj.
//   Raw clk/data are synchronised, clk is glitch-filtered, and 11-bit frames
//   (start, 8 data LSB first, odd parity, stop) are shifted in on filtered
//   clock falls. E0/F0 prefixes are folded into is_ext/is_break on the next
//   code byte unless RAW_MODE is set.
//
//   reloj      in   system clock (50 MHz)
//   reset      in   asynchronous active-low reset
//   clk, data  in   raw PS/2 lines, asynchronous to reloj
//   scancode   out  last decoded code byte
//   valid_out  out  high for VALID_HOLD cycles per decoded code
//   is_break   out  code was preceded by F0
//   is_ext     out  code was preceded by E0
//   parity_err out  one-cycle pulse on a frame with bad parity
//   frame_err  out  one-cycle pulse on bad stop bit or mid-frame timeout
//
//   state    | meaning
//   S_IDLE   | waiting for a start bit (sampled 0)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | checking stop bit and parity, accepting the byte

module ps2_rx_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int VALID_HOLD  = 4,
    parameter int RAW_MODE    = 0
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       clk,
    input  logic       data,
    output logic [7:0] scancode,
    output logic       valid_out,
    output logic       is_break,
    output logic       is_ext,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam int HCW = $clog2(VALID_HOLD + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYC - 1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(VALID_HOLD);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   filt_q, filt_d;
    logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
    logic [TCW-1:0]         to_cnt_q, to_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   par_q, par_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   brk_pend_q, brk_pend_d;
    logic [7:0]             scancode_q, scancode_d;
    logic                   is_ext_q, is_ext_d;
    logic                   is_break_q, is_break_d;
    logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;

    logic clk_s, data_s, fall_ev, timeout;
    logic stop_fall, parity_ok, accept, is_e0, is_prefix, emit;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Synchroniser and clock filter: the filtered clock only follows the
    // synced clock after FILT_LEN consecutive differing samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_LAST) filt_d = clk_s;
            else                         filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall_ev = filt_q & ~filt_d;
    end

    // Timeout counter; a fall event in the same cycle wins over expiry.
    always_comb begin
        timeout  = (state_q != S_IDLE) && !fall_ev && (to_cnt_q == TO_LAST);
        to_cnt_d = to_cnt_q + 1'b1;
        if (fall_ev || state_q == S_IDLE || timeout) to_cnt_d = '0;
    end

    // FSM: state register
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (fall_ev) begin
            case (state_q)
                S_IDLE:   if (!data_s) state_d = S_DATA;
                S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs (frame checks)
    always_comb begin
        stop_fall    = fall_ev && (state_q == S_STOP);
        parity_ok    = ^{par_q, shift_q};
        accept       = stop_fall && data_s && parity_ok;
        frame_err_d  = timeout || (stop_fall && !data_s);
        parity_err_d = stop_fall && data_s && !parity_ok;
    end

    // Shift register, bit counter and parity capture
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        if (fall_ev) begin
            case (state_q)
                S_IDLE:   bit_cnt_d = '0;
                S_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                S_PARITY: par_d = data_s;
                default:  ;
            endcase
        end
    end

    // Prefix folding and output registers
    always_comb begin
        is_e0      = (shift_q == 8'hE0);
        is_prefix  = (RAW_MODE == 0) && (is_e0 || shift_q == 8'hF0);
        emit       = accept && !is_prefix;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        if (accept && is_prefix) begin
            if (is_e0) ext_pend_d = 1'b1;
            else       brk_pend_d = 1'b1;
        end
        if (emit) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
        scancode_d = emit ? shift_q    : scancode_q;
        is_ext_d   = emit ? ext_pend_q : is_ext_q;
        is_break_d = emit ? brk_pend_q : is_break_q;
        hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - 1'b1 : '0;
        if (emit) hold_cnt_d = HOLD_LOAD;
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            to_cnt_q     <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            scancode_q   <= '0;
            is_ext_q     <= 1'b0;
            is_break_q   <= 1'b0;
            hold_cnt_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            to_cnt_q     <= to_cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_q        <= par_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            scancode_q   <= scancode_d;
            is_ext_q     <= is_ext_d;
            is_break_q   <= is_break_d;
            hold_cnt_q   <= hold_cnt_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign scancode   = scancode_q;
    assign valid_out  = (hold_cnt_q != '0);
    assign is_break   = is_break_q;
    assign is_ext     = is_ext_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Testbench for ps2_rx_decoder. Two instances share the PS/2 lines: one
// decoding prefixes, one in RAW_MODE. The PS/2 bit period is shortened to
// 2*HALF reloj cycles and TIMEOUT_CYC scaled down to keep the run short.
`timescale 1ns/1ps
module tb_ps2_rx_decoder;

    localparam int SYNC = 2, FILT = 8, TMO = 200, HOLD = 4, HALF = 20;

    logic reloj = 1'b0, reset = 1'b0, clk = 1'b1, data = 1'b1;
    always #10 reloj = ~reloj;

    logic [7:0] sc0, sc1;
    logic vo0, vo1, brk0, brk1, ext0, ext1, pe0, pe1, fe0, fe1;

    ps2_rx_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .TIMEOUT_CYC(TMO),
                     .VALID_HOLD(HOLD), .RAW_MODE(0)) dut0 (
        .reloj(reloj), .reset(reset), .clk(clk), .data(data),
        .scancode(sc0), .valid_out(vo0), .is_break(brk0), .is_ext(ext0),
        .parity_err(pe0), .frame_err(fe0));

    ps2_rx_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .TIMEOUT_CYC(TMO),
                     .VALID_HOLD(HOLD), .RAW_MODE(1)) dut1 (
        .reloj(reloj), .reset(reset), .clk(clk), .data(data),
        .scancode(sc1), .valid_out(vo1), .is_break(brk1), .is_ext(ext1),
        .parity_err(pe1), .frame_err(fe1));

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } exp_t;

    exp_t sb0[$], sb1[$];
    exp_t e0m, e1m;
    int n_checks = 0, n_errors = 0;
    int exp_perr = 0, exp_ferr = 0;
    int obs_perr0 = 0, obs_ferr0 = 0, obs_perr1 = 0, obs_ferr1 = 0;
    logic m_ext = 1'b0, m_brk = 1'b0;
    logic [7:0] exp_sc0 = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge reloj);
    endtask

    task automatic model_accept(input logic [7:0] b);
        sb1.push_back('{code: b, ext: 1'b0, brk: 1'b0});
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            sb0.push_back('{code: b, ext: m_ext, brk: m_brk});
            exp_sc0 = b;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        data = b;
        if (glitch) begin
            wait_cyc(5); clk = 1'b0; wait_cyc(3); clk = 1'b1; wait_cyc(HALF - 8);
        end else begin
            wait_cyc(HALF);
        end
        clk = 1'b0;
        wait_cyc(HALF);
        clk = 1'b1;
    endtask

    // glitch_bit: 0 = start bit, 1..8 = data bits, -1 = none
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                              input int glitch_bit);
        logic par;
        par = (~^b) ^ bad_par;
        if (!stop)        exp_ferr++;
        else if (bad_par) exp_perr++;
        else              model_accept(b);
        send_bit(1'b0, glitch_bit == 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1);
        send_bit(par, 1'b0);
        send_bit(stop, 1'b0);
        data = 1'b1;
        wait_cyc(30);
    endtask

    task automatic check_err_counts(input string tag);
        check({tag, "_perr0"}, obs_perr0, exp_perr);
        check({tag, "_ferr0"}, obs_ferr0, exp_ferr);
        check({tag, "_perr1"}, obs_perr1, exp_perr);
        check({tag, "_ferr1"}, obs_ferr1, exp_ferr);
    endtask

    // Output monitor: pops the scoreboard on each valid rise, checks hold
    // length on each fall and error pulse widths.
    logic pv0 = 1'b0, pv1 = 1'b0, ppe0 = 1'b0, ppe1 = 1'b0, pfe0 = 1'b0, pfe1 = 1'b0;
    int hl0 = 0, hl1 = 0;

    always @(negedge reloj) begin
        if (!reset) begin
            pv0 = 1'b0; pv1 = 1'b0; hl0 = 0; hl1 = 0;
            ppe0 = 1'b0; ppe1 = 1'b0; pfe0 = 1'b0; pfe1 = 1'b0;
        end else begin
            if (vo0 && !pv0) begin
                if (sb0.size() == 0) check("dut0_unexpected_valid", sc0, 32'hFFFF);
                else begin
                    e0m = sb0.pop_front();
                    check("dut0_code", sc0, e0m.code);
                    check("dut0_ext", ext0, e0m.ext);
                    check("dut0_brk", brk0, e0m.brk);
                end
            end
            if (vo1 && !pv1) begin
                if (sb1.size() == 0) check("dut1_unexpected_valid", sc1, 32'hFFFF);
                else begin
                    e1m = sb1.pop_front();
                    check("dut1_code", sc1, e1m.code);
                    check("dut1_ext", ext1, e1m.ext);
                    check("dut1_brk", brk1, e1m.brk);
                end
            end
            if (vo0) hl0++;
            else if (pv0) begin check("dut0_hold", hl0, HOLD); hl0 = 0; end
            if (vo1) hl1++;
            else if (pv1) begin check("dut1_hold", hl1, HOLD); hl1 = 0; end
            if (pe0) begin obs_perr0++; check("dut0_perr_width", ppe0, 0); end
            if (pe1) begin obs_perr1++; check("dut1_perr_width", ppe1, 0); end
            if (fe0) begin obs_ferr0++; check("dut0_ferr_width", pfe0, 0); end
            if (fe1) begin obs_ferr1++; check("dut1_ferr_width", pfe1, 0); end
            pv0 = vo0; pv1 = vo1; ppe0 = pe0; ppe1 = pe1; pfe0 = fe0; pfe1 = fe1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        logic [7:0] pb;
        // Reset state
        wait_cyc(3);
        check("rst_outs0", {sc0, vo0, brk0, ext0, pe0, fe0}, 0);
        check("rst_outs1", {sc1, vo1, brk1, ext1, pe1, fe1}, 0);
        reset = 1'b1;
        wait_cyc(20);

        // 1: plain make code
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        check_err_counts("t1");

        // 2: break prefix, then a bare code
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b1, -1);

        // 3: extended break
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        check_err_counts("t3");

        // 4: bad parity, bad stop
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        check("t4_keep_code_par", sc0, exp_sc0);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        check("t4_keep_code_stop", sc0, exp_sc0);
        check_err_counts("t4");

        // 5: truncated frame times out, then a good frame
        pb = 8'h0B;
        exp_ferr++;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(pb[i], 1'b0);
        data = pb[4];
        wait_cyc(HALF);
        clk = 1'b0;
        first = -1;
        for (int n = 1; n <= SYNC + FILT + TMO + 20; n++) begin
            @(negedge reloj);
            if (n == HALF) clk = 1'b1;
            if (fe0 && first < 0) first = n;
        end
        data = 1'b1;
        check("t5_timeout_cycle", first, SYNC + FILT + TMO);
        send_frame(8'h29, 1'b0, 1'b1, -1);
        check_err_counts("t5");

        // 6: glitches in idle and mid-data, then reset mid-frame
        clk = 1'b0; wait_cyc(3); clk = 1'b1; wait_cyc(30);
        send_frame(8'h1C, 1'b0, 1'b1, 3);
        check_err_counts("t6_glitch");
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(pb[i], 1'b0);
        data = pb[4];
        wait_cyc(5);
        reset = 1'b0;
        #1;
        check("t6_rst_outs0", {sc0, vo0, brk0, ext0, pe0, fe0}, 0);
        check("t6_rst_outs1", {sc1, vo1, brk1, ext1, pe1, fe1}, 0);
        clk = 1'b1; data = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; exp_sc0 = 8'h00;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(20);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        check_err_counts("t6_end");

        check("sb0_left", sb0.size(), 0);
        check("sb1_left", sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
